// File: rtl/spi_regfile_peripheral_pkg.sv
// Shared definitions for the SPI register-file peripheral.
//   state_t   : frame-parser FSM states (IDLE, CMD, DATA, HOLD, ERR)
//   frame_len : bits per frame = 1 R/W bit + address bits + data bits
//   cnt_width : bit-counter width that can hold FRAME_LEN without wrapping
package spi_regfile_peripheral_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_HOLD = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // The counter has to reach FRAME_LEN itself (the HOLD count), hence +1.
  function automatic int cnt_width(input int flen);
    return $clog2(flen + 1);
  endfunction

  localparam int DEF_FRAME_LEN = frame_len(7, 8);
  localparam int DEF_CNT_W     = cnt_width(DEF_FRAME_LEN);

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI bus between an external controller and the register-file peripheral.
//   sclk_raw, mosi_raw, cs_n_raw : controller -> peripheral, asynchronous
//   miso, miso_oe                : peripheral -> controller
// Bus protocol (mode 0): cs_n low opens a frame; the controller changes
// mosi while sclk is low and both sides sample on sclk rising edges; the
// peripheral changes miso after sclk falling edges. A frame is MSB-first:
// R/W bit (1 = write), address, data. cs_n high closes the frame, and only
// then is a complete write committed.
interface spi_regfile_peripheral_if;
  logic sclk_raw;
  logic mosi_raw;
  logic cs_n_raw;
  logic miso;
  logic miso_oe;

  modport master (output sclk_raw, output mosi_raw, output cs_n_raw,
                  input miso, input miso_oe);
  modport slave  (input sclk_raw, input mosi_raw, input cs_n_raw,
                  output miso, output miso_oe);
endinterface

// File: rtl/spi_regfile_peripheral_sync_edge.sv
// spi_sync_edge: brings the asynchronous SPI pins into the clk domain.
//   clk, rst                     : system clock, async active-high reset
//   sclk_raw, mosi_raw, cs_n_raw : raw bus pins
//   sclk_rise, sclk_fall         : one-cycle strobes on synchronised sclk edges
//   mosi_s, cs_n_s               : synchronised mosi / cs_n levels
//   cs_rise, cs_fall             : one-cycle strobes on synchronised cs_n edges
// Flops reset to an idle bus (sclk 0, mosi 0, cs_n 1).
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sclk_raw,
  input  logic mosi_raw,
  input  logic cs_n_raw,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi_s,
  output logic cs_n_s,
  output logic cs_rise,
  output logic cs_fall
);

  logic [1:0] sclk_sync, mosi_sync, cs_sync;
  logic       sclk_d, cs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk_raw};
      mosi_sync <= {mosi_sync[0], mosi_raw};
      cs_sync   <= {cs_sync[0], cs_n_raw};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign mosi_s    = mosi_sync[1];
  assign cs_n_s    = cs_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_rise   = cs_sync[1] & ~cs_d;
  assign cs_fall   = ~cs_sync[1] & cs_d;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI (mode 0) slave that writes a small register file.
//   clk, rst  : system clock (>= 8x sclk), async active-high reset
//   bus       : SPI pins (slave modport)
//   regs_out  : register n at [n*DATA_W +: DATA_W]
//   wr_pulse  : one-cycle strobe per committed write; wr_addr holds its address
//   frame_err : one-cycle strobe per aborted or overlong frame
//   state_dbg : current parser state
// Optional feature macro SPI_REGFILE_READBACK_EN: read frames return the
// addressed register on miso (0 when out of range). Without it miso and
// miso_oe are tied low.
module spi_regfile_peripheral
  import spi_regfile_peripheral_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_regfile_peripheral_if.slave    bus,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err,
  output state_t                     state_dbg
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = cnt_width(FRAME_LEN);
  // Counter value seen on the rising edge that completes each phase.
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_LEN - 1);

  logic sclk_rise, sclk_fall, mosi_s, cs_n_s, cs_rise, cs_fall;

  spi_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk_raw  (bus.sclk_raw),
    .mosi_raw  (bus.mosi_raw),
    .cs_n_raw  (bus.cs_n_raw),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi_s    (mosi_s),
    .cs_n_s    (cs_n_s),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall)
  );

  state_t               state_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [FRAME_LEN-1:0] shift_q, shift_nx;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  // After reset the synchroniser starts at cs_n=1, so a bus already low
  // would look like a fresh fall. armed_q only rises once cs_n has really
  // been seen high after the synchroniser has flushed.
  logic [1:0]           settle_q;
  logic                 armed_q;

  logic                 frame_wr, wr_hit;
  logic [ADDR_W-1:0]    frame_addr;
  logic [DATA_W-1:0]    frame_data;

  assign shift_nx   = {shift_q[FRAME_LEN-2:0], mosi_s};
  assign frame_wr   = shift_q[FRAME_LEN-1];
  assign frame_addr = shift_q[FRAME_LEN-2 -: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];

  always_comb begin
    wr_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (frame_addr == ADDR_W'(i)) wr_hit = 1'b1;
  end

`ifdef SPI_REGFILE_READBACK_EN
  logic              cmd_wr, miso_q, oe_q;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] rd_val, shadow_q;

  // Command as it stands including the bit arriving on this edge.
  assign cmd_wr   = shift_nx[ADDR_W];
  assign cmd_addr = shift_nx[ADDR_W-1:0];

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (cmd_addr == ADDR_W'(i)) rd_val = regs_q[i];
  end

  assign bus.miso    = miso_q;
  assign bus.miso_oe = oe_q;
`else
  logic unused_fall;
  assign unused_fall = sclk_fall;
  assign bus.miso    = 1'b0;
  assign bus.miso_oe = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      settle_q  <= 2'b00;
      armed_q   <= 1'b0;
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
`ifdef SPI_REGFILE_READBACK_EN
      shadow_q  <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
`endif
    end else begin
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      settle_q  <= {settle_q[0], 1'b1};
      armed_q   <= armed_q | (settle_q[1] & cs_n_s);
      if (cs_rise) begin
        // Frame closes: commit only a complete in-range write.
        if (state_q == ST_HOLD) begin
          if (frame_wr && wr_hit) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (frame_addr == ADDR_W'(i)) regs_q[i] <= frame_data;
            wr_pulse <= 1'b1;
            wr_addr  <= frame_addr;
          end
        end else if (state_q != ST_IDLE) begin
          frame_err <= 1'b1;
        end
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        shift_q   <= '0;
`ifdef SPI_REGFILE_READBACK_EN
        shadow_q  <= '0;
        miso_q    <= 1'b0;
        oe_q      <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: if (cs_fall && armed_q) state_q <= ST_CMD;
          ST_CMD: begin
            if (sclk_rise) begin
              shift_q   <= shift_nx;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == CMD_LAST) begin
                state_q <= ST_DATA;
`ifdef SPI_REGFILE_READBACK_EN
                if (!cmd_wr) begin
                  shadow_q <= rd_val;
                  oe_q     <= 1'b1;
                end
`endif
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              shift_q   <= shift_nx;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == DATA_LAST) state_q <= ST_HOLD;
            end
          end
          ST_HOLD: if (sclk_rise) state_q <= ST_ERR;
          default: ;
        endcase
`ifdef SPI_REGFILE_READBACK_EN
        if (oe_q && sclk_fall) begin
          miso_q   <= shadow_q[DATA_W-1];
          shadow_q <= shadow_q << 1;
        end
`endif
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
module tb_spi_regfile_peripheral;
  import spi_regfile_peripheral_pkg::*;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int HALF     = 8;   // clk cycles per sclk half period
`ifdef SPI_REGFILE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_regfile_peripheral_if bus ();

  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic                       wr_pulse, frame_err;
  logic [ADDR_W-1:0]          wr_addr;
  state_t                     state_dbg;

  spi_regfile_peripheral dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .regs_out  (regs_out),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .frame_err (frame_err),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0]        model_regs [NUM_REGS];
  logic [ADDR_W-1:0]        model_wr_addr;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int                       exp_err = 0;
  bit                       mon_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
    model_wr_addr = '0;
    exp_q.delete();
    exp_err = 0;
  endtask

  // Per-cycle compare against the model.
  logic [ADDR_W+DATA_W-1:0] mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_pulse === 1'b1) begin
        chk("wr_pulse_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          model_regs[int'(mon_e[DATA_W +: ADDR_W])] = mon_e[DATA_W-1:0];
          model_wr_addr = mon_e[DATA_W +: ADDR_W];
        end
      end
      if (frame_err === 1'b1) begin
        chk("frame_err_expected", 64'(exp_err > 0), 64'd1);
        if (exp_err > 0) exp_err--;
      end
      chk("regs_out", regs_out, model_flat());
      chk("wr_addr", wr_addr, model_wr_addr);
`ifndef SPI_REGFILE_READBACK_EN
      chk("miso_const", bus.miso, 0);
      chk("miso_oe_const", bus.miso_oe, 0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_regs"}, regs_out, 0);
    chk({tag, "_wr_pulse"}, wr_pulse, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_miso"}, bus.miso, 0);
    chk({tag, "_miso_oe"}, bus.miso_oe, 0);
    chk({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  task automatic apply_mid_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
  endtask

  task automatic spi_frame(input logic [31:0] word, input int nbits, input int rst_at,
                           output logic [7:0] rd_bits, output logic [7:0] oe_bits);
    rd_bits = '0;
    oe_bits = '0;
    bus.cs_n_raw = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) apply_mid_reset();
      bus.mosi_raw = word[nbits-1-i];
      wait_clk(HALF);
      if (i >= 8 && i < 16) begin
        rd_bits[15-i] = bus.miso;
        oe_bits[15-i] = bus.miso_oe;
      end
      bus.sclk_raw = 1'b1;
      wait_clk(HALF);
      bus.sclk_raw = 1'b0;
    end
    wait_clk(HALF);
    bus.cs_n_raw = 1'b1;
    bus.mosi_raw = 1'b0;
    wait_clk(12);
  endtask

  // Expected outcome straight from the frame rules: 16 bits is a complete
  // frame; anything else is malformed; a reset mid-frame yields nothing.
  task automatic do_frame(input logic [31:0] word, input int nbits, input int rst_at,
                          output logic [7:0] rd_bits);
    logic [7:0]        oe_bits, exp_rd;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    rw     = word[15];
    addr   = word[14:8];
    data   = word[7:0];
    exp_rd = '0;
    if (rst_at < 0) begin
      if (nbits == 16) begin
        if (rw && addr < NUM_REGS) exp_q.push_back({addr, data});
        if (!rw && RB && addr < NUM_REGS) exp_rd = model_regs[int'(addr)];
      end else begin
        exp_err++;
      end
    end
    spi_frame(word, nbits, rst_at, rd_bits, oe_bits);
    chk("pending_wr", 64'(exp_q.size()), 0);
    chk("pending_err", 64'(exp_err), 0);
    if (nbits == 16 && !rw && rst_at < 0) begin
      chk("miso_data", rd_bits, exp_rd);
      chk("miso_oe_data", oe_bits, RB ? 8'hFF : 8'h00);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  rd;
    logic [31:0] word;
    int          kind, nbits;
    bus.sclk_raw = 1'b0;
    bus.mosi_raw = 1'b0;
    bus.cs_n_raw = 1'b1;
    rst = 1'b1;
    model_reset();
    wait_clk(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(5);
    mon_en = 1'b1;

    // Write 0x84 to addr 2.
    do_frame(32'h8284, 16, -1, rd);
    chk("lit_reg2", regs_out[23:16], 8'h84);
    chk("lit_wr_addr2", wr_addr, 2);
    chk("lit_others", {regs_out[39:24], regs_out[15:0]}, 0);

    // Out-of-range write: nothing changes.
    do_frame(32'h85FF, 16, -1, rd);
    chk("lit_oob_regs", regs_out, 40'h00_0084_0000);
    chk("lit_oob_wr_addr", wr_addr, 2);

    // Abort after 10 bits, then a valid frame.
    do_frame(32'h8111 >> 6, 10, -1, rd);
    chk("lit_abort_regs", regs_out, 40'h00_0084_0000);
    do_frame(32'h8111, 16, -1, rd);
    chk("lit_after_abort", regs_out, 40'h00_0084_1100);

    // 17-bit frame: overlong, no commit.
    do_frame((32'h8377 << 1) | 32'h1, 17, -1, rd);
    chk("lit_long_reg3", regs_out[31:24], 8'h00);

    // Readback of 0xA5 from reg 4, and an out-of-range read.
    do_frame(32'h84A5, 16, -1, rd);
    chk("lit_reg4", regs_out[39:32], 8'hA5);
    do_frame(32'h0400, 16, -1, rd);
    chk("lit_miso_a5", rd, RB ? 8'hA5 : 8'h00);
    do_frame(32'h0733, 16, -1, rd);
    chk("lit_miso_oob", rd, 8'h00);

    // Reset at bit 12 of a write, then a clean frame.
    do_frame(32'h803C, 16, 12, rd);
    chk("lit_after_rst", regs_out, 0);
    do_frame(32'h803C, 16, -1, rd);
    chk("lit_post_rst", regs_out, 40'h00_0000_003C);
    chk("lit_post_rst_addr", wr_addr, 0);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        word  = {16'h0, 1'b1, 7'($urandom_range(0, 7)), 8'($urandom)};
        nbits = 16;
      end else if (kind < 7) begin
        word  = {16'h0, 1'b0, 7'($urandom_range(0, 7)), 8'($urandom)};
        nbits = 16;
      end else if (kind < 9) begin
        word  = $urandom;
        nbits = $urandom_range(0, 15);
      end else begin
        word  = $urandom;
        nbits = $urandom_range(17, 20);
      end
      do_frame(word, nbits, -1, rd);
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_regfile_peripheral.md
SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter NUM_REGS, default 5, number of writable registers (1..2^ADDR_W).
REQ-003 Parameter DATA_W, default 8, register and data-field width.
REQ-004 Parameter ADDR_W, default 7, address-field width.
REQ-005 Parameter RESET_VAL, default 0, reset value of every register (DATA_W bits).
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 sclk_raw, mosi_raw, cs_n_raw  input  1 each  asynchronous SPI mode-0 bus.
REQ-009 miso  output  1  read data to controller.
REQ-010 miso_oe  output  1  high while a read frame's data phase is active.
REQ-011 regs_out  output  NUM_REGS*DATA_W  register file, register n at bits [n*DATA_W +: DATA_W].
REQ-012 wr_pulse  output  1  one-cycle strobe on each committed write.
REQ-013 wr_addr  output  ADDR_W  address of the last committed write.
REQ-014 frame_err  output  1  one-cycle strobe on each aborted or overlong frame.

Function
REQ-015 Each raw input SHALL pass a 2-flop synchroniser; sclk edges detected against a third flop; clk SHALL be at least 8x sclk.
REQ-016 Frame SHALL be MSB-first: 1 R/W bit (1=write), ADDR_W address bits, DATA_W data bits; FRAME_LEN = 1+ADDR_W+DATA_W.
REQ-017 MOSI SHALL be sampled on synchronised sclk rising edges only while synchronised cs_n is low.
REQ-018 FSM states SHALL be IDLE, CMD, DATA, HOLD, ERR.
REQ-019 IDLE->CMD on synchronised cs_n falling; CMD->DATA after 1+ADDR_W rising edges; DATA->HOLD after DATA_W further rising edges.
REQ-020 Any rising edge in HOLD SHALL go to ERR (overlong frame); ERR ignores further edges.
REQ-021 cs_n rise in HOLD with write and address < NUM_REGS SHALL update that register next cycle, pulse wr_pulse one cycle, update wr_addr.
REQ-022 cs_n rise in HOLD with address >= NUM_REGS, or with a read, SHALL change no register and raise no strobe.
REQ-023 cs_n rise in CMD, DATA or ERR SHALL discard the frame and pulse frame_err one cycle; cs_n rise in IDLE is ignored.
REQ-024 Every cs_n rise SHALL return FSM to IDLE and clear bit counter and shift register.
REQ-025 Bit counter SHALL be sized for FRAME_LEN and never wrap within a frame.

Reset
REQ-026 rst SHALL asynchronously set FSM to IDLE, counter and shift register to 0, synchroniser flops to idle bus (sclk 0, mosi 0, cs_n 1), every register to RESET_VAL, wr_addr 0, wr_pulse, frame_err, miso, miso_oe to 0.
REQ-027 Reset mid-frame SHALL discard the frame without strobes; the next frame starts only after a fresh cs_n fall.

Configuration
REQ-028 Macro SPI_REGFILE_READBACK_EN defined: on CMD->DATA of a read, SHALL load register[addr] (0 if out of range) into a shadow, drive its MSB on the next synchronised sclk falling edge, shift one bit per later falling edge, miso_oe high until cs_n rise.
REQ-029 Macro undefined: miso and miso_oe SHALL be constant 0; read frames still parse and still flag frame_err if malformed.

Structure
REQ-030 Shared package SHALL hold the FSM state enum and FRAME_LEN/counter-width helper constants.
REQ-031 One sub-module spi_sync_edge SHALL provide the synchroniser and sclk rise/fall detection.

Verification
REQ-032 Write 0x84 to addr 2 (frame 0x8284) -> reg 2 = 0x84, wr_pulse once, wr_addr 2, others unchanged.
REQ-033 Write addr 5 with NUM_REGS=5 (frame 0x85FF) -> no register change, no wr_pulse, no frame_err.
REQ-034 cs_n rises after 10 bits -> frame_err once, registers unchanged; next valid frame commits.
REQ-035 17-bit frame -> frame_err once, no commit.
REQ-036 With READBACK_EN, reg 4 = 0xA5, read frame 0x04xx -> miso shifts 1,0,1,0,0,1,0,1 on data rising edges; without it miso stays 0.
REQ-037 rst asserted at bit 12 of a write -> all outputs reset immediately, no wr_pulse, following frame correct.
